// File: rtl/cov_mon_pkg.sv
// Shared types and constants for the cov_out_monitor slice.
package cov_mon_pkg;

    localparam int unsigned NUM_BINS = 8;
    localparam int unsigned SEL_W    = 2;

    // Readout handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } rd_state_t;

    // rd_sel encodings
    localparam logic [SEL_W-1:0] SEL_C1  = 2'd0;
    localparam logic [SEL_W-1:0] SEL_C2  = 2'd1;
    localparam logic [SEL_W-1:0] SEL_C3  = 2'd2;
    localparam logic [SEL_W-1:0] SEL_MAP = 2'd3;

endpackage

// File: rtl/cov_rise_cnt.sv
// One channel of the monitor: history flop, rise detector and edge counter.
// Build option COV_MON_SAT_EN: counter saturates at all-ones instead of wrapping.
module cov_rise_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_nxt_c
);

    logic             s_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise_c;

    assign rise_c = din & ~s_q;

    // Next counter value; also feeds the top-level snapshot so a readout sees this edge's update
    always_comb begin
        cnt_nxt_c = cnt_q;
        if (clr) begin
            cnt_nxt_c = '0;
        end else if (rise_c) begin
`ifdef COV_MON_SAT_EN
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_nxt_c = cnt_q + CNT_W'(1);
            end
`else
            cnt_nxt_c = cnt_q + CNT_W'(1);
`endif
        end
    end

    // History flop is never cleared so a level held through clr does not recount
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            s_q   <= din;
            cnt_q <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/cov_out_monitor.sv
// Coverage monitor for cov_test outputs: per-output rise counters, combination
// bin map and a four-phase readout port. Build option COV_MON_SAT_EN selects
// saturating counters (default: wrapping).
module cov_out_monitor
    import cov_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                in1,
    input  logic                in2,
    input  logic                in3,
    input  logic                clr,
    input  logic [SEL_W-1:0]    rd_sel,
    input  logic                rd_req,
    output logic                rd_ack,
    output logic [CNT_W-1:0]    rd_data,
    output logic [NUM_BINS-1:0] bin_map,
    output logic                all_hit
);

    localparam int unsigned NUM_CH = 3;

    logic [NUM_CH-1:0]   ch_in_c;
    logic [CNT_W-1:0]    cnt_nxt_c [NUM_CH];
    logic [2:0]          bin_idx_c;
    logic [NUM_BINS-1:0] bin_map_nxt_c;
    logic [CNT_W-1:0]    snap_c;

    rd_state_t           state_q;
    rd_state_t           state_nxt_c;
    logic                ack_nxt_c;
    logic [CNT_W-1:0]    data_nxt_c;

    // Channel 0 is in1, channel 2 is in3
    assign ch_in_c = {in3, in2, in1};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cov_rise_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (CLK),
            .rst_n     (RSTn),
            .din       (ch_in_c[g]),
            .clr       (clr),
            .cnt_nxt_c (cnt_nxt_c[g])
        );
    end

    assign bin_idx_c = {in1, in2, in3};
    assign all_hit   = &bin_map;

    // Sticky combination bins; clr wins over this edge's hit
    always_comb begin
        bin_map_nxt_c = bin_map | (NUM_BINS'(1) << bin_idx_c);
        if (clr) begin
            bin_map_nxt_c = '0;
        end
    end

    // Bin map register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bin_map <= '0;
        end else begin
            bin_map <= bin_map_nxt_c;
        end
    end

    // Readout source, taken from post-edge values so the snapshot includes the accepting edge
    always_comb begin
        snap_c = '0;
        case (rd_sel)
            SEL_C1:  snap_c = cnt_nxt_c[0];
            SEL_C2:  snap_c = cnt_nxt_c[1];
            SEL_C3:  snap_c = cnt_nxt_c[2];
            SEL_MAP: snap_c = CNT_W'(bin_map_nxt_c);
            default: snap_c = '0;
        endcase
    end

    // Handshake next state, registered ack and snapshot
    always_comb begin
        state_nxt_c = state_q;
        ack_nxt_c   = 1'b0;
        data_nxt_c  = rd_data;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_nxt_c = ACK;
                    ack_nxt_c   = 1'b1;
                    data_nxt_c  = snap_c;
                end
            end
            ACK: begin
                if (!rd_req) begin
                    state_nxt_c = DONE;
                end else begin
                    ack_nxt_c = 1'b1;
                end
            end
            DONE: begin
                state_nxt_c = IDLE;
            end
            default: begin
                state_nxt_c = IDLE;
            end
        endcase
    end

    // Handshake state register; async reset drops ack immediately
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            state_q <= state_nxt_c;
            rd_ack  <= ack_nxt_c;
            rd_data <= data_nxt_c;
        end
    end

endmodule

// File: tb/tb_cov_out_monitor.sv
// Self-checking bench for cov_out_monitor: two widths driven in parallel and
// compared against a rise-count / bin-set reference model.
module tb_cov_out_monitor;

    localparam int W_A = 8;
    localparam int W_B = 4;

    logic           CLK = 1'b0;
    logic           RSTn = 1'b0;
    logic           in1 = 1'b0, in2 = 1'b0, in3 = 1'b0;
    logic           clr = 1'b0;
    logic [1:0]     rd_sel = 2'd0;
    logic           rd_req = 1'b0;

    logic           rd_ack_a, rd_ack_b;
    logic [W_A-1:0] rd_data_a;
    logic [W_B-1:0] rd_data_b;
    logic [7:0]     bin_map_a, bin_map_b;
    logic           all_hit_a, all_hit_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: rises since last clear per channel, set of seen combinations
    int         raw [3];
    bit         prv [3];
    logic [7:0] mmap;

    always #5 CLK = ~CLK;

    cov_out_monitor #(.CNT_W(W_A)) u_dut_a (
        .CLK(CLK), .RSTn(RSTn), .in1(in1), .in2(in2), .in3(in3), .clr(clr),
        .rd_sel(rd_sel), .rd_req(rd_req), .rd_ack(rd_ack_a), .rd_data(rd_data_a),
        .bin_map(bin_map_a), .all_hit(all_hit_a)
    );

    cov_out_monitor #(.CNT_W(W_B)) u_dut_b (
        .CLK(CLK), .RSTn(RSTn), .in1(in1), .in2(in2), .in3(in3), .clr(clr),
        .rd_sel(rd_sel), .rd_req(rd_req), .rd_ack(rd_ack_b), .rd_data(rd_data_b),
        .bin_map(bin_map_b), .all_hit(all_hit_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int raw_v, input int w);
        int mx;
        mx = (1 << w) - 1;
`ifdef COV_MON_SAT_EN
        return (raw_v > mx) ? mx : raw_v;
`else
        return raw_v & mx;
`endif
    endfunction

    function automatic int exp_sel(input int sel, input int w);
        if (sel < 3) return exp_cnt(raw[sel], w);
        return int'(mmap) & ((1 << w) - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            raw[i] = 0;
            prv[i] = 1'b0;
        end
        mmap = 8'h00;
    endtask

    task automatic model_edge();
        bit cur [3];
        int idx;
        if (!RSTn) return;
        cur[0] = in1; cur[1] = in2; cur[2] = in3;
        idx = {29'd0, in1, in2, in3};
        for (int i = 0; i < 3; i++) begin
            if (clr) raw[i] = 0;
            else if (cur[i] && !prv[i]) raw[i] = raw[i] + 1;
            prv[i] = cur[i];
        end
        if (clr) mmap = 8'h00;
        else mmap[idx] = 1'b1;
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later
    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        chk("bin_map_a", 32'(bin_map_a), 32'(mmap));
        chk("bin_map_b", 32'(bin_map_b), 32'(mmap));
        chk("all_hit", 32'(all_hit_a), 32'(&mmap));
    endtask

    task automatic set_in(input int v);
        in1 = v[2]; in2 = v[1]; in3 = v[0];
    endtask

    task automatic rise_in(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            if (ch == 0) in1 = 1'b1; else if (ch == 1) in2 = 1'b1; else in3 = 1'b1;
            tick();
            if (ch == 0) in1 = 1'b0; else if (ch == 1) in2 = 1'b0; else in3 = 1'b0;
            tick();
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Raise request; ack and snapshot must appear after the accepting edge
    task automatic rd_start(input int sel);
        chk("ack_idle", 32'(rd_ack_a), 32'd0);
        rd_sel = 2'(sel);
        rd_req = 1'b1;
        tick();
        chk("ack_rise_a", 32'(rd_ack_a), 32'd1);
        chk("ack_rise_b", 32'(rd_ack_b), 32'd1);
        chk("snap_a", 32'(rd_data_a), 32'(exp_sel(sel, W_A)));
        chk("snap_b", 32'(rd_data_b), 32'(exp_sel(sel, W_B)));
    endtask

    task automatic rd_end();
        rd_req = 1'b0;
        tick();
        chk("ack_fall_a", 32'(rd_ack_a), 32'd0);
        chk("ack_fall_b", 32'(rd_ack_b), 32'd0);
        tick();
        chk("ack_done", 32'(rd_ack_a), 32'd0);
    endtask

    task automatic readout(input int sel);
        logic [W_A-1:0] held;
        rd_start(sel);
        held = rd_data_a;
        tick();
        chk("ack_hold", 32'(rd_ack_a), 32'd1);
        chk("data_hold", 32'(rd_data_a), 32'(held));
        rd_end();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ack", 32'(rd_ack_a), 32'd0);
        chk("rst_data", 32'(rd_data_a), 32'd0);
        chk("rst_map", 32'(bin_map_a), 32'd0);
        chk("rst_all_hit", 32'(all_hit_a), 32'd0);

        // Walk 001, 011, 111 then hold
        set_in(3'b001);
        RSTn = 1'b1;
        tick();
        set_in(3'b011);
        tick();
        set_in(3'b111);
        tick();
        tick();
        chk("t1_map", 32'(bin_map_a), 32'h8A);
        chk("t1_all_hit", 32'(all_hit_a), 32'd0);
        for (int s = 0; s < 4; s++) readout(s);

        // Ten rises on in1 from a cleared counter
        do_clr();
        set_in(3'b000);
        tick();
        rise_in(0, 10);
        rd_start(0);
        chk("t2_cnt1", 32'(rd_data_a), 32'd10);
        tick();
        rd_end();

        // Full bin walk, then clr with in1 held high
        for (int v = 0; v < 8; v++) begin
            set_in(v);
            tick();
        end
        chk("t3_full", 32'(bin_map_a), 32'hFF);
        chk("t3_all_hit", 32'(all_hit_a), 32'd1);
        set_in(3'b100);
        tick();
        do_clr();
        chk("t3_clr_map", 32'(bin_map_a), 32'd0);
        tick();
        chk("t3_cur_bin", 32'(bin_map_a), 32'h10);
        rd_start(0);
        chk("t3_cnt1", 32'(rd_data_a), 32'd0);
        tick();
        rd_end();

        // Seventeen rises on in2: 4-bit counter saturates or wraps
        set_in(3'b000);
        do_clr();
        rise_in(1, 17);
        rd_start(1);
`ifdef COV_MON_SAT_EN
        chk("t4_cnt2_w4", 32'(rd_data_b), 32'd15);
`else
        chk("t4_cnt2_w4", 32'(rd_data_b), 32'd1);
`endif
        chk("t4_cnt2_w8", 32'(rd_data_a), 32'd17);
        tick();
        rd_end();

        // Snapshot frozen while counting continues
        do_clr();
        rise_in(0, 5);
        rd_start(0);
        chk("t5_snap", 32'(rd_data_a), 32'd5);
        for (int k = 0; k < 3; k++) begin
            in1 = 1'b1;
            tick();
            chk("t5_frozen", 32'(rd_data_a), 32'd5);
            in1 = 1'b0;
            tick();
            chk("t5_ack_held", 32'(rd_ack_a), 32'd1);
        end
        rd_end();
        rd_start(0);
        chk("t5_next", 32'(rd_data_a), 32'd8);
        tick();
        rd_end();

        // Reset in ACK: immediate drop, then a held request is accepted after release
        rise_in(2, 2);
        rd_start(2);
        RSTn = 1'b0;
        #1;
        chk("t6_ack_a", 32'(rd_ack_a), 32'd0);
        chk("t6_ack_b", 32'(rd_ack_b), 32'd0);
        chk("t6_data", 32'(rd_data_a), 32'd0);
        chk("t6_map", 32'(bin_map_a), 32'd0);
        model_reset();
        set_in(3'b000);
        rd_sel = 2'd1;
        @(negedge CLK);
        RSTn = 1'b1;
        tick();
        chk("t6_reaccept", 32'(rd_ack_a), 32'd1);
        chk("t6_cnt2", 32'(rd_data_a), 32'd0);
        tick();
        rd_end();
        readout(0);
        readout(2);
        readout(3);

        // Randomized traffic with periodic readouts
        for (int it = 0; it < 400; it++) begin
            set_in(int'($urandom_range(7)));
            clr = ($urandom_range(15) == 0);
            tick();
            clr = 1'b0;
            if ((it % 25) == 24) readout(int'($urandom_range(3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
